mux2_unit: RTL and testbench
============================

Name: mux2_unit

Overview:
- Two-input, WIDTH-bit data multiplexer with a zero-latency combinational output and a one-cycle registered copy.
- The registered copy carries a valid qualifier and a select-toggle statistics counter.
- Used as the basic selection element in datapath steering logic; the combinational path serves glue logic, the registered path serves timing-closed pipelines.

Parameters:
- WIDTH, 1, data width of d0, d1, z and z_q.
- CNT_W, 16, width of the select-toggle counter.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous active-low reset; assertion is immediate, deassertion is synchronous to clk.
- d0  input  WIDTH  data input 0.
- d1  input  WIDTH  data input 1.
- sel  input  1  select: 0 chooses d0, 1 chooses d1.
- in_valid  input  1  qualifies d0/d1/sel for the registered path.
- clr_cnt  input  1  synchronous clear of toggle_cnt.
- z  output  WIDTH  combinational mux result.
- z_q  output  WIDTH  registered mux result.
- out_valid  output  1  z_q holds a valid sample.
- toggle_cnt  output  CNT_W  number of registered sel transitions, saturating.

Behaviour:
- z = sel ? d1 : d0, purely combinational, zero latency.
- z is independent of clk and rst_n, and valid during reset.
- With sel=0, z follows d0 bit-for-bit and d1 is ignored. With sel=1, the reverse.
- X/Z on sel: z need not be defined; the bench drives only 0/1.
- Reset (rst_n=0, asynchronous): z_q=0, out_valid=0, toggle_cnt=0, internal sel_prev=0.
- Registered path, per rising clk edge with rst_n=1:
  - in_valid=1: z_q <= (sel ? d1 : d0); out_valid <= 1.
  - in_valid=0: z_q holds its previous value; out_valid <= 0.
  - Latency is exactly 1 cycle from an in_valid sample to out_valid/z_q.
- Toggle counter, only on cycles with in_valid=1:
  - If sel != sel_prev, toggle_cnt increments by 1, saturating at 2^CNT_W-1 (no wrap).
  - sel_prev <= sel.
  - The first valid sample after reset compares against sel_prev=0.
- clr_cnt=1 sets toggle_cnt to 0 on the next edge and takes priority over a simultaneous increment. sel_prev still updates in that cycle.
- Reset asserted mid-stream clears all registered state immediately. The first edge after release behaves as the first sample after reset.
- No handshake back-pressure; every valid input is accepted.

Optional Feature:
- Macro: MUX2_UNIT_PARITY_EN.
- Defined: adds output port z_par (1 bit).
  - z_par is registered with z_q and equals the even parity (XOR reduction) of the value loaded into z_q.
  - z_par holds alongside z_q, and resets to 0.
- Undefined: port z_par and its logic are absent. All other behaviour is identical.

Test Plan:
- Combinational truth table, WIDTH=1, sel/d0/d1 swept over all 8 combinations, 50 time units each -> z = 0,0,1,1,0,1,0,1 in order (sel,d0,d1 = 000…111).
- Reset: drive rst_n=0 between clock edges -> z_q=0, out_valid=0 and toggle_cnt=0 immediately; z still tracks inputs.
- Registered path: in_valid=1, sel=1, d1=1, d0=0 for one cycle, then in_valid=0 -> next edge z_q=1 and out_valid=1; the following edge out_valid=0 and z_q stays 1.
- Toggle counting: valid sel sequence 1,1,0,1,0 -> toggle_cnt=4. Apply clr_cnt together with one more toggle -> toggle_cnt=0.
- Saturation with CNT_W=2: 5 valid toggles -> toggle_cnt stays 3.
- With MUX2_UNIT_PARITY_EN, WIDTH=4: d1=4'b1011, sel=1, in_valid=1 -> z_q=4'b1011, z_par=1.

Source files
------------

// File: rtl/mux2_unit.sv
// ---------------------------------------------------------------------------
// mux2_unit
//
// This is a two-input, WIDTH-bit data multiplexer with two outputs:
//   - a zero-latency combinational output (z), and
//   - a one-cycle registered copy (z_q).
// The registered copy carries a valid qualifier and a counter that records
// how many times the select changes (toggle statistics).
//
// Optional build:
//   `define MUX2_UNIT_PARITY_EN adds the output port z_par. z_par is the even
//   parity (XOR reduction) of the value loaded into z_q, and it is registered
//   together with z_q.
//
// Parameters:
//   WIDTH      data width of d0, d1, z and z_q
//   CNT_W      width of the saturating select-toggle counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   d0, d1     data inputs (sel=0 picks d0, sel=1 picks d1)
//   sel        select
//   in_valid   qualifies d0/d1/sel for the registered path
//   clr_cnt    synchronous clear of toggle_cnt; takes priority over an increment
//   z          combinational mux result; valid during reset
//   z_q        registered mux result; holds when in_valid=0
//   out_valid  z_q was loaded on the last edge
//   toggle_cnt count of sel changes between valid samples; saturates
//   z_par      (MUX2_UNIT_PARITY_EN only) parity of z_q
// ---------------------------------------------------------------------------
module mux2_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] toggle_cnt
`ifdef MUX2_UNIT_PARITY_EN
    ,
    output logic             z_par
`endif
);

    // Select value from the most recent valid sample. After reset it is 0,
    // so a first valid sample with sel=1 counts as a toggle.
    logic sel_prev;
    logic cnt_sat;
    logic toggled;

    assign z       = sel ? d1 : d0;
    assign cnt_sat = (toggle_cnt == {CNT_W{1'b1}});
    assign toggled = in_valid && (sel != sel_prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q       <= '0;
            out_valid <= 1'b0;
            sel_prev  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                z_q      <= z;
                sel_prev <= sel;
            end
        end
    end

    // The clear wins over a simultaneous toggle. sel_prev still advances
    // above in that cycle, so the next toggle is measured from the new sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_cnt <= '0;
        end else if (clr_cnt) begin
            toggle_cnt <= '0;
        end else if (toggled && !cnt_sat) begin
            toggle_cnt <= toggle_cnt + CNT_W'(1);
        end
    end

`ifdef MUX2_UNIT_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_par <= 1'b0;
        end else if (in_valid) begin
            z_par <= ^z;
        end
    end
`endif

endmodule

// File: tb/tb_mux2_unit.sv
module tb_mux2_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       sel;
    logic       in_valid;
    logic       clr_cnt;

    // Instance a: WIDTH=1, CNT_W=16. Instance b: WIDTH=4, CNT_W=2 (saturation).
    logic        z_a, zq_a, ov_a;
    logic [15:0] cnt_a;
    logic [3:0]  z_b, zq_b;
    logic        ov_b;
    logic [1:0]  cnt_b;
`ifdef MUX2_UNIT_PARITY_EN
    logic        par_a, par_b;
`endif

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    mux2_unit #(.WIDTH(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .d0(d0[0]), .d1(d1[0]), .sel(sel),
        .in_valid(in_valid), .clr_cnt(clr_cnt), .z(z_a), .z_q(zq_a),
        .out_valid(ov_a), .toggle_cnt(cnt_a)
`ifdef MUX2_UNIT_PARITY_EN
        , .z_par(par_a)
`endif
    );

    mux2_unit #(.WIDTH(4), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .sel(sel),
        .in_valid(in_valid), .clr_cnt(clr_cnt), .z(z_b), .z_q(zq_b),
        .out_valid(ov_b), .toggle_cnt(cnt_b)
`ifdef MUX2_UNIT_PARITY_EN
        , .z_par(par_b)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the registered path seen as "last valid pick" plus a
    // count of select changes between valid samples, clipped at the maximum.
    int m_zq_a, m_zq_b, m_par_a, m_par_b, m_ov, m_cnt_a, m_cnt_b, m_prev, picked;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_zq_a = 0; m_zq_b = 0; m_par_a = 0; m_par_b = 0; m_ov = 0;
            m_cnt_a = 0; m_cnt_b = 0; m_prev = 0;
        end else begin
            picked = sel ? int'(d1) : int'(d0);
            m_ov = in_valid;
            if (clr_cnt) begin
                m_cnt_a = 0;
                m_cnt_b = 0;
            end else if (in_valid && int'(sel) != m_prev) begin
                m_cnt_a = (m_cnt_a + 1 > 65535) ? 65535 : m_cnt_a + 1;
                m_cnt_b = (m_cnt_b + 1 > 3) ? 3 : m_cnt_b + 1;
            end
            if (in_valid) begin
                m_zq_b  = picked;
                m_zq_a  = picked % 2;
                m_par_b = $countones(picked) % 2;
                m_par_a = picked % 2;
                m_prev  = sel;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("z_a",   z_a,   sel ? d1[0] : d0[0]);
            check("z_b",   z_b,   sel ? d1 : d0);
            check("zq_a",  zq_a,  m_zq_a);
            check("zq_b",  zq_b,  m_zq_b);
            check("ov_a",  ov_a,  m_ov);
            check("ov_b",  ov_b,  m_ov);
            check("cnt_a", cnt_a, m_cnt_a);
            check("cnt_b", cnt_b, m_cnt_b);
`ifdef MUX2_UNIT_PARITY_EN
            check("par_a", par_a, m_par_a);
            check("par_b", par_b, m_par_b);
`endif
        end
    end

    task automatic apply(input logic s, input logic [3:0] a0, input logic [3:0] a1,
                         input logic v, input logic c);
        sel = s; d0 = a0; d1 = a1; in_valid = v; clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] tt;
    logic [4:0] seq;

    initial begin
        rst_n = 0; d0 = 0; d1 = 0; sel = 0; in_valid = 0; clr_cnt = 0;
        tt = 8'b1010_1100;

        // Combinational truth table, swept while reset is asserted.
        for (int i = 0; i < 8; i++) begin
            sel = i[2]; d0 = {3'b000, i[1]}; d1 = {3'b000, i[0]};
            #50;
            check("tt_z", z_a, tt[i]);
        end
        check("rst_zq", zq_a, 0);
        check("rst_ov", ov_a, 0);

        apply(0, 0, 0, 0, 0);
        rst_n = 1;
        check_en = 1;

        // Single valid sample, then idle.
        apply(1, 4'h0, 4'h1, 1, 0);
        check("reg_zq", zq_a, 1);
        check("reg_ov", ov_a, 1);
        check("reg_cnt", cnt_a, 1);
        apply(1, 4'h0, 4'h1, 0, 0);
        check("hold_zq", zq_a, 1);
        check("hold_ov", ov_a, 0);

        // Mid-cycle reset clears registered state immediately; z keeps working.
        sel = 0; d0 = 4'h5; d1 = 4'hA;
        #2;
        rst_n = 0;
        #1;
        check("mrst_zq", zq_b, 0);
        check("mrst_ov", ov_b, 0);
        check("mrst_cnt", cnt_a, 0);
        check("mrst_z", z_b, 4'h5);
        @(posedge clk);
        #1;
        rst_n = 1;

        // Valid sel sequence 1,1,0,1,0 gives four toggles.
        seq = 5'b01011;
        for (int i = 0; i < 5; i++) apply(seq[i], 4'h3, 4'hC, 1, 0);
        check("tog_cnt_a", cnt_a, 4);
        check("tog_cnt_b", cnt_b, 3);
        check("tog_zq_b", zq_b, 4'h3);

        // Clear wins over a simultaneous toggle.
        apply(1, 4'h3, 4'hC, 1, 1);
        check("clr_cnt_a", cnt_a, 0);
        check("clr_cnt_b", cnt_b, 0);

        // Five more toggles: 16-bit counter reaches 5, 2-bit counter sticks at 3.
        for (int i = 0; i < 5; i++) apply(i[0], 4'h6, 4'h9, 1, 0);
        check("sat_cnt_a", cnt_a, 5);
        check("sat_cnt_b", cnt_b, 3);

        // Parity load, then hold.
        apply(1, 4'h0, 4'b1011, 1, 0);
        check("par_zq_b", zq_b, 4'b1011);
`ifdef MUX2_UNIT_PARITY_EN
        check("par_lit", par_b, 1);
`endif
        apply(0, 4'h0, 4'h0, 0, 0);
        check("par_hold_zq", zq_b, 4'b1011);
        apply(0, 4'h0, 4'h0, 0, 0);

        check_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
